// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: accepts a WIDTH-bit request mask and emits the
// index of every set bit, one beat per cycle, in MSB-first or LSB-first order.
module prio_encoder_seq #(
  parameter int WIDTH     = 8,
  parameter int OUT_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             out_last,
  output logic             zero
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] pending_r;
  logic [OUT_W-1:0] dout_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             zero_r;

  logic [WIDTH-1:0] scan_src_s;
  logic [WIDTH-1:0] scan_rem_s;
  logic [OUT_W-1:0] scan_idx_s;
  logic             scan_empty_s;

  // Winning index of a mask; the later match in scan order takes priority.
  // An all-zero mask yields index 0, which is exactly the zero-beat value.
  function automatic logic [OUT_W-1:0] prio_index(input logic [WIDTH-1:0] mask);
    logic [OUT_W-1:0] idx;
    idx = {OUT_W{1'b0}};
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        idx = mask[i] ? OUT_W'(i) : idx;
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        idx = mask[i] ? OUT_W'(i) : idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [WIDTH-1:0] onehot(input logic [OUT_W-1:0] idx);
    logic [WIDTH-1:0] bm;
    bm      = {WIDTH{1'b0}};
    bm[idx] = 1'b1;
    return bm;
  endfunction

  // Scan the incoming mask in IDLE so the first beat is ready one cycle after acceptance
  always_comb begin
    scan_src_s = pending_r;
    if (state_r == IDLE) begin
      scan_src_s = din;
    end else begin
      scan_src_s = pending_r;
    end
    scan_idx_s   = prio_index(scan_src_s);
    scan_rem_s   = scan_src_s & ~onehot(scan_idx_s);
    scan_empty_s = (scan_rem_s == {WIDTH{1'b0}});
  end

  // Handshake FSM with registered beat outputs; a stalled beat holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pending_r   <= {WIDTH{1'b0}};
      dout_r      <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            pending_r   <= scan_rem_s;
            dout_r      <= scan_idx_s;
            out_valid_r <= 1'b1;
            out_last_r  <= scan_empty_s;
            zero_r      <= (din == {WIDTH{1'b0}});
            state_r     <= EMIT;
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          if (out_valid_r && out_ready) begin
            if (out_last_r) begin
              dout_r      <= {OUT_W{1'b0}};
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              zero_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              pending_r  <= scan_rem_s;
              dout_r     <= scan_idx_s;
              out_last_r <= scan_empty_s;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r     <= IDLE;
          pending_r   <= {WIDTH{1'b0}};
          dout_r      <= {OUT_W{1'b0}};
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          zero_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign dout      = dout_r;
  assign out_last  = out_last_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Self-checking bench: two 8-bit encoders (MSB/LSB first) share stimulus,
// plus a 32-bit MSB-first instance; checked against queue-based expectations.
module tb_prio_encoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid8, out_ready8;
  logic [7:0]  din8;
  logic        in_valid32, out_ready32;
  logic [31:0] din32;

  logic       m_in_ready, m_out_valid, m_out_last, m_zero;
  logic [2:0] m_dout;
  logic       l_in_ready, l_out_valid, l_out_last, l_zero;
  logic [2:0] l_dout;
  logic       w_in_ready, w_out_valid, w_out_last, w_zero;
  logic [4:0] w_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(m_in_ready), .din(din8),
    .out_valid(m_out_valid), .out_ready(out_ready8), .dout(m_dout), .out_last(m_out_last), .zero(m_zero));

  prio_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(l_in_ready), .din(din8),
    .out_valid(l_out_valid), .out_ready(out_ready8), .dout(l_dout), .out_last(l_out_last), .zero(l_zero));

  prio_encoder_seq #(.WIDTH(32), .MSB_FIRST(1'b1)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(w_in_ready), .din(din32),
    .out_valid(w_out_valid), .out_ready(out_ready32), .dout(w_dout), .out_last(w_out_last), .zero(w_zero));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_chk8(input string tag);
    chk({tag, "_m_valid"}, 32'(m_out_valid), 32'd0);
    chk({tag, "_m_dout"},  32'(m_dout),      32'd0);
    chk({tag, "_m_last"},  32'(m_out_last),  32'd0);
    chk({tag, "_m_zero"},  32'(m_zero),      32'd0);
    chk({tag, "_m_ready"}, 32'(m_in_ready),  32'd1);
    chk({tag, "_l_valid"}, 32'(l_out_valid), 32'd0);
    chk({tag, "_l_dout"},  32'(l_dout),      32'd0);
    chk({tag, "_l_ready"}, 32'(l_in_ready),  32'd1);
  endtask

  // Send one mask to both 8-bit encoders and follow every beat to the end.
  task automatic run8(input logic [7:0] mask, input int stall_first, input bit rnd);
    int qm[$];
    int ql[$];
    int cyc;
    for (int i = 7; i >= 0; i--) if (mask[i]) qm.push_back(i);
    for (int i = 0; i < 8; i++)  if (mask[i]) ql.push_back(i);
    if (mask == 8'd0) begin
      qm.push_back(0);
      ql.push_back(0);
    end
    in_valid8 = 1'b1;
    din8      = mask;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    din8      = 8'($urandom);
    cyc       = 0;
    while (qm.size() > 0) begin
      chk("m_valid", 32'(m_out_valid), 32'd1);
      chk("m_dout",  32'(m_dout),      32'(qm[0]));
      chk("m_last",  32'(m_out_last),  32'(qm.size() == 1));
      chk("m_zero",  32'(m_zero),      32'(mask == 8'd0));
      chk("m_busy",  32'(m_in_ready),  32'd0);
      chk("l_valid", 32'(l_out_valid), 32'd1);
      chk("l_dout",  32'(l_dout),      32'(ql[0]));
      chk("l_last",  32'(l_out_last),  32'(ql.size() == 1));
      chk("l_zero",  32'(l_zero),      32'(mask == 8'd0));
      if (cyc < stall_first) out_ready8 = 1'b0;
      else if (rnd)          out_ready8 = ($urandom_range(0, 2) != 0);
      else                   out_ready8 = 1'b1;
      in_valid8 = 1'($urandom_range(0, 1));
      din8      = 8'($urandom);
      @(posedge clk); #1;
      if (out_ready8) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      cyc++;
      if (cyc > 200) begin
        checks++;
        errors++;
        $error("FAIL beat_budget8: observed=%0d expected<=200", cyc);
        break;
      end
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    idle_chk8("after8");
  endtask

  task automatic run32(input logic [31:0] mask, input bit rnd);
    int q[$];
    int cyc;
    for (int i = 31; i >= 0; i--) if (mask[i]) q.push_back(i);
    if (mask == 32'd0) q.push_back(0);
    chk("w_ready", 32'(w_in_ready), 32'd1);
    in_valid32 = 1'b1;
    din32      = mask;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    din32      = $urandom;
    cyc        = 0;
    while (q.size() > 0) begin
      chk("w_valid", 32'(w_out_valid), 32'd1);
      chk("w_dout",  32'(w_dout),      32'(q[0]));
      chk("w_last",  32'(w_out_last),  32'(q.size() == 1));
      chk("w_zero",  32'(w_zero),      32'(mask == 32'd0));
      out_ready32 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid32  = 1'($urandom_range(0, 1));
      din32       = $urandom;
      @(posedge clk); #1;
      if (out_ready32) void'(q.pop_front());
      cyc++;
      if (cyc > 400) begin
        checks++;
        errors++;
        $error("FAIL beat_budget32: observed=%0d expected<=400", cyc);
        break;
      end
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b0;
    chk("w_end_valid", 32'(w_out_valid), 32'd0);
    chk("w_end_dout",  32'(w_dout),      32'd0);
    chk("w_end_ready", 32'(w_in_ready),  32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  m8;
    logic [31:0] m32;
    rst_n = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; din8 = 8'd0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; din32 = 32'd0;
    #3;
    idle_chk8("reset");
    chk("reset_w_valid", 32'(w_out_valid), 32'd0);
    chk("reset_w_ready", 32'(w_in_ready),  32'd1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    run8(8'b11001000, 0, 1'b0);
    run8(8'b00000000, 0, 1'b0);
    run8(8'b10000000, 0, 1'b0);
    run8(8'b00010010, 3, 1'b0);

    // Reset in the middle of an 8'hFF burst after two beats.
    in_valid8 = 1'b1; din8 = 8'hFF;
    @(posedge clk); #1;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    chk("burst_m_b0", 32'(m_dout), 32'd7);
    chk("burst_l_b0", 32'(l_dout), 32'd0);
    @(posedge clk); #1;
    chk("burst_m_b1", 32'(m_dout), 32'd6);
    chk("burst_l_b1", 32'(l_dout), 32'd1);
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    idle_chk8("midreset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run8(8'b00000001, 0, 1'b0);

    run32(32'h8000_0001, 1'b0);
    run32(32'h0000_0000, 1'b0);

    for (int k = 0; k < 20; k++) begin
      m8 = 8'($urandom);
      if (k % 3 == 1) m8 = m8 & 8'($urandom);
      if (k == 7) m8 = 8'd0;
      run8(m8, int'($urandom_range(0, 2)), 1'b1);
    end
    for (int k = 0; k < 20; k++) begin
      m32 = $urandom;
      if (k % 2 == 1) m32 = m32 & $urandom & $urandom;
      run32(m32, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_encoder_seq.md
Name: prio_encoder_seq

Overview:
- Parametrised, sequential successor to the team's combinational 8-to-3 encoder.
- Accepts a WIDTH-bit request mask through a valid/ready handshake.
- Emits the binary index of every set bit, one index per output beat, in configurable priority order. Flags the last beat and the all-zero mask case.
- Sits between request-mask producers (interrupt/status collectors) and downstream index consumers that need every asserted line, not just the highest.

Parameters:
- WIDTH, 8, request mask width; legal range 2..256.
- OUT_W, $clog2(WIDTH), index output width; derived, do not override.
- MSB_FIRST, 1, 1 = highest set index emitted first; 0 = lowest set index first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  din holds a mask to accept
- in_ready  output  1  block can accept a mask (high only in IDLE)
- din  input  WIDTH  request mask
- out_valid  output  1  dout/out_last/zero are valid
- out_ready  input  1  downstream accepts current beat
- dout  output  OUT_W  index of the current emitted bit
- out_last  output  1  current beat is the final beat for this mask
- zero  output  1  accepted mask was all zeros; dout=0 on that beat

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pending=0.
  - out_valid=0, dout=0, out_last=0, zero=0, in_ready=1.
  - Reset mid-burst discards remaining pending bits; no further beats for that mask.
- States: IDLE and EMIT.
  - in_ready = (state==IDLE).
- IDLE:
  - Accept on the edge where in_valid && in_ready.
  - pending <= din; state -> EMIT.
  - The output register is loaded on the same edge, so out_valid is high the cycle after acceptance (latency 1).
- First beat loaded at acceptance:
  - din==0: dout=0, zero=1, out_last=1.
  - Otherwise: dout = priority index of din, zero=0, out_last = (popcount(din)==1).
  - The emitted bit is cleared from pending on that same edge.
- EMIT:
  - Output beat handshake = out_valid && out_ready.
  - On a handshake with out_last=0: load the next priority index from pending, clear that bit, set out_last if it was the final set bit. One beat per cycle under continuous out_ready.
  - On a handshake with out_last=1: out_valid <= 0, state -> IDLE.
- Backpressure:
  - While out_valid && !out_ready, dout/out_last/zero/out_valid hold stable; pending is unchanged.
- Ordering:
  - MSB_FIRST=1: descending index.
  - MSB_FIRST=0: ascending index.
  - Every set bit is emitted exactly once; beat count = max(1, popcount(din)).
- Back-to-back masks:
  - One idle cycle minimum between masks.
  - in_ready rises the cycle after the last-beat handshake.
  - in_valid in EMIT is ignored (not captured).
- din is only sampled at acceptance; changes afterwards have no effect.
- No X propagation: dout=0 whenever out_valid=0.
- Priority select is a combinational scan of pending. For WIDTH up to 256 it is not pipelined further.

Test Plan (WIDTH=8 unless noted):
- MSB_FIRST=1, out_ready=1, din=8'b11001000 -> dout 7,6,3 on consecutive cycles starting 1 cycle after accept; out_last only on 3; zero=0; in_ready high again the cycle after.
- MSB_FIRST=0, din=8'b11001000 -> dout 3,6,7; out_last on 7.
- din=8'b00000000 -> single beat: dout=0, zero=1, out_last=1. din=8'b10000000 -> single beat: dout=7, zero=0, out_last=1.
- Backpressure: din=8'b00010010, out_ready low for 3 cycles after out_valid -> dout=4 held stable for 3 cycles; then out_ready=1 -> 4 then 1; in_valid pulsed during EMIT is not accepted.
- Reset mid-burst: din=8'hFF, rst_n low after 2 beats (7,6) -> out_valid=0 and in_ready=1 immediately (async); after release, new din=8'b00000001 -> single beat dout=0, zero=0, out_last=1.
- WIDTH=32, OUT_W=5, din=32'h8000_0001, MSB_FIRST=1 -> dout 31 then 0; out_last on 0; random masks vs reference model (popcount beats, order, indices).
